max_unpool_nn: RTL and testbench
================================

# max_unpool_nn

Nearest-neighbour unpooling (upsampling) engine: the inverse of the 2D max-pooling stage. It reads a (ROW_SIZE/KERNEL_DIM)² pooled feature map from one BRAM and writes a ROW_SIZE² map to a second BRAM. Each pooled word is replicated into its KERNEL_DIM×KERNEL_DIM output window. It talks to the same synchronous-read BRAM model (registered read data, one-cycle read latency) and runs one pass per `start` pulse.

## Interface
- ADDR_WIDTH, 4, read/write address width; must satisfy 2**ADDR_WIDTH ≥ ROW_SIZE².
- DATA_WIDTH, 8, word width.
- KERNEL_DIM, 2, window edge; must be ≥ 2.
- ROW_SIZE, 4, output map edge; must be a multiple of KERNEL_DIM.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; honoured only in IDLE.
- busy  out  1  high from FETCH through the last WRITE cycle.
- done  out  1  one-cycle pulse after the final write.
- rd_addr  out  ADDR_WIDTH  pooled-map read address.
- rd_data  in  DATA_WIDTH  pooled word, valid one cycle after rd_addr.
- wr_addr  out  ADDR_WIDTH  output-map write address.
- wr_data  out  DATA_WIDTH  replicated word.
- wr_en  out  1  write strobe.

## Operation
- Derived constants: P = ROW_SIZE/KERNEL_DIM (pooled edge), N_SRC = P², KK = KERNEL_DIM².
- Counters: src_idx (0..N_SRC-1, split as pr = src_idx / P, pc = src_idx % P), kern_cnt (0..KK-1, split as kr = kern_cnt / KERNEL_DIM, kc = kern_cnt % KERNEL_DIM), hold_val register.
- FSM states IDLE, FETCH, LATCH, WRITE, DONE:
  - IDLE: start=1 → FETCH; src_idx=0, kern_cnt=0.
  - FETCH: rd_addr=src_idx; → LATCH.
  - LATCH: hold_val ← rd_data; rd_addr = src_idx+1, clamped to N_SRC-1; → WRITE.
  - WRITE:
    - wr_en=1, wr_data=hold_val, wr_addr=(pr·KERNEL_DIM+kr)·ROW_SIZE + pc·KERNEL_DIM + kc, truncated to ADDR_WIDTH.
    - rd_addr = min(src_idx+1, N_SRC-1) (prefetch).
    - kern_cnt increments each cycle. At kern_cnt==KK-1: hold_val ← rd_data, kern_cnt ← 0, src_idx+1.
    - If src_idx==N_SRC-1 at kern_cnt==KK-1 → DONE; otherwise stay in WRITE.
  - DONE: done=1 for one cycle → IDLE.
- Write order: window by window in source raster order. Inside each window kc varies fastest, then kr.
- start outside IDLE (including in DONE) is ignored; it is not queued.
- rst at any cycle: the next cycle is IDLE and all outputs are 0. No write occurs in the reset cycle or after it; a partially written map is left as is.
- Outputs wr_en, wr_addr, wr_data, rd_addr, busy and done decode combinationally from state and registers. They are 0 in IDLE, and wr_* are 0 outside WRITE.

## Timing
- Reset value of every output: 0.
- start sampled at cycle 0 → FETCH at cycle 1, LATCH at cycle 2, first write at cycle 3.
- Steady state: exactly one write per cycle, no bubbles between windows. The prefetch address is stable from the first WRITE cycle of a window, so rd_data is valid by kern_cnt==KK-1 because KK ≥ 2.
- Total: ROW_SIZE² writes in cycles 3 .. 2+ROW_SIZE²; done in cycle 3+ROW_SIZE².
- Earliest next start: the cycle after done (back in IDLE).

## Structure
- Package `pool_pkg`:
  - unpool_state_t enum (IDLE, FETCH, LATCH, WRITE, DONE).
  - Shared KERNEL_DIM/ROW_SIZE default localparams.
  - Function computing the window write address from (pr, pc, kr, kc). The pooling block may adopt the same function.
- One natural sub-module: `unpool_addr_gen`. It holds the src_idx/kern_cnt counters and produces rd_addr, wr_addr and a last_in_window/last_src flag; the top level keeps the FSM and hold_val.
- The test bench instantiates the existing BRAM model twice: a source map and a destination map.

## Test plan
- Defaults, source mem = {10,20,30,40}, start pulse → destination = {10,10,20,20, 10,10,20,20, 30,30,40,40, 30,30,40,40}; 16 consecutive wr_en cycles 3..18; done only at cycle 19.
- Write-address trace with defaults → 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15; rd_addr never exceeds 3.
- start held high continuously → back-to-back passes, each starting exactly one cycle after done; busy low only in the DONE cycle and the IDLE cycle after it.
- rst asserted at cycle 8 of a pass → wr_en=0 from cycle 8 on; destination words not yet written keep their prior value; a new start then produces the full correct map.
- ROW_SIZE=8, KERNEL_DIM=4, ADDR_WIDTH=6, source = {0xFF,0x00,0x7F,0x80} → each 4×4 quadrant is uniform with the matching value; done at cycle 67.

Source files
------------

// File: rtl/max_unpool_nn_pkg.sv
// Shared types, default geometry and window addressing for the pooling/unpooling engines.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } unpool_state_t;

    localparam int DEF_KERNEL_DIM = 2;
    localparam int DEF_ROW_SIZE   = 4;

    // Linear address of element (kr, kc) inside the window of pooled cell (pr, pc).
    function automatic int unsigned window_addr(
        input int unsigned pr,
        input int unsigned pc,
        input int unsigned kr,
        input int unsigned kc,
        input int unsigned kernel_dim,
        input int unsigned row_size
    );
        return (pr * kernel_dim + kr) * row_size + pc * kernel_dim + kc;
    endfunction

endpackage

// File: rtl/max_unpool_nn_if.sv
// Control and BRAM-side signals of the unpooling engine.
interface max_unpool_nn_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    modport master (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_addr,
        input  wr_addr,
        input  wr_data,
        input  wr_en
    );

    modport slave (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_addr,
        output wr_addr,
        output wr_data,
        output wr_en
    );
endinterface

// File: rtl/max_unpool_nn_addr_gen.sv
// Source/kernel counters of the unpooling engine and the read/write addresses derived from them.
module unpool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int ROW_SIZE   = DEF_ROW_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  last_in_window,
    output logic                  last_src
);

    localparam int unsigned P     = ROW_SIZE / KERNEL_DIM;
    localparam int unsigned K     = KERNEL_DIM;
    localparam int unsigned N_SRC = P * P;
    localparam int unsigned KK    = K * K;
    localparam int          SW    = $clog2(N_SRC + 1);
    localparam int          KW    = $clog2(KK + 1);

    localparam logic [SW-1:0] SRC_LAST  = SW'(N_SRC - 1);
    localparam logic [KW-1:0] KERN_LAST = KW'(KK - 1);

    logic [SW-1:0] src_idx_r;
    logic [KW-1:0] kern_cnt_r;
    logic [SW-1:0] src_next_s;
    int unsigned   pr_s;
    int unsigned   pc_s;
    int unsigned   kr_s;
    int unsigned   kc_s;

    // Counter update: kern_cnt walks the window, src_idx steps (and wraps) at the window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_idx_r  <= '0;
            kern_cnt_r <= '0;
        end else if (clear) begin
            src_idx_r  <= '0;
            kern_cnt_r <= '0;
        end else if (advance) begin
            if (kern_cnt_r == KERN_LAST) begin
                kern_cnt_r <= '0;
                if (src_idx_r == SRC_LAST) begin
                    src_idx_r <= '0;
                end else begin
                    src_idx_r <= src_idx_r + SW'(1);
                end
            end else begin
                kern_cnt_r <= kern_cnt_r + KW'(1);
                src_idx_r  <= src_idx_r;
            end
        end else begin
            src_idx_r  <= src_idx_r;
            kern_cnt_r <= kern_cnt_r;
        end
    end

    // Address decode; the prefetch address saturates on the last source word.
    always_comb begin
        last_in_window = (kern_cnt_r == KERN_LAST);
        last_src       = (src_idx_r == SRC_LAST);
        if (last_src) begin
            src_next_s = src_idx_r;
        end else begin
            src_next_s = src_idx_r + SW'(1);
        end
        pr_s      = 32'(src_idx_r) / P;
        pc_s      = 32'(src_idx_r) % P;
        kr_s      = 32'(kern_cnt_r) / K;
        kc_s      = 32'(kern_cnt_r) % K;
        cur_addr  = ADDR_WIDTH'(src_idx_r);
        next_addr = ADDR_WIDTH'(src_next_s);
        wr_addr   = ADDR_WIDTH'(window_addr(pr_s, pc_s, kr_s, kc_s, K, 32'(ROW_SIZE)));
    end

endmodule

// File: rtl/max_unpool_nn.sv
// Nearest-neighbour unpooling engine: replicates each pooled word over its KERNEL_DIM x KERNEL_DIM window.
module max_unpool_nn
    import pool_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int ROW_SIZE   = DEF_ROW_SIZE
) (
    input logic            clk,
    input logic            rst,
    max_unpool_nn_if.slave bus
);

    unpool_state_t         state_r;
    unpool_state_t         state_nxt_s;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  clear_s;
    logic                  advance_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic                  last_in_window_s;
    logic                  last_src_s;

    assign clear_s   = (state_r == IDLE) && bus.start;
    assign advance_s = (state_r == WRITE);

    unpool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .KERNEL_DIM (KERNEL_DIM),
        .ROW_SIZE   (ROW_SIZE)
    ) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear_s),
        .advance        (advance_s),
        .cur_addr       (cur_addr_s),
        .next_addr      (next_addr_s),
        .wr_addr        (wr_addr_s),
        .last_in_window (last_in_window_s),
        .last_src       (last_src_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // hold_val: first word loads in LATCH, later words at each window end from the prefetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= '0;
        end else if ((state_r == LATCH) || ((state_r == WRITE) && last_in_window_s)) begin
            hold_r <= bus.rd_data;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH:   state_nxt_s = LATCH;
            LATCH:   state_nxt_s = WRITE;
            WRITE: begin
                if (last_in_window_s && last_src_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; a reset cycle forces everything low so no write can slip through.
    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        if (!rst) begin
            case (state_r)
                FETCH: begin
                    bus.busy    = 1'b1;
                    bus.rd_addr = cur_addr_s;
                end
                LATCH: begin
                    bus.busy    = 1'b1;
                    bus.rd_addr = next_addr_s;
                end
                WRITE: begin
                    bus.busy    = 1'b1;
                    bus.rd_addr = next_addr_s;
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = wr_addr_s;
                    bus.wr_data = hold_r;
                end
                DONE: begin
                    bus.done = 1'b1;
                end
                default: begin
                    bus.busy = 1'b0;
                end
            endcase
        end else begin
            bus.busy    = 1'b0;
            bus.done    = 1'b0;
            bus.rd_addr = '0;
            bus.wr_en   = 1'b0;
        end
    end

endmodule

// File: tb/tb_max_unpool_nn.sv
// Self-checking bench for max_unpool_nn: cycle-level reference model plus literal checks on two geometries.
module tb_max_unpool_nn;

    localparam int AW = 4, DW = 8, K = 2, R = 4;
    localparam int P = R / K, NS = P * P, KK = K * K, RR = R * R, DONE_T = 3 + RR;
    localparam int AW8 = 6, K8 = 4, R8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst8;
    max_unpool_nn_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) bus ();
    max_unpool_nn_if #(.ADDR_WIDTH(AW8), .DATA_WIDTH(DW)) bus8 ();

    max_unpool_nn #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KERNEL_DIM(K), .ROW_SIZE(R)) u_dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
    max_unpool_nn #(.ADDR_WIDTH(AW8), .DATA_WIDTH(DW), .KERNEL_DIM(K8), .ROW_SIZE(R8)) u_dut8 (
        .clk (clk), .rst (rst8), .bus (bus8.slave));

    logic [DW-1:0] src_mem [NS];
    logic [DW-1:0] dst_mem [RR];
    logic [DW-1:0] exp_dst [RR];
    logic [DW-1:0] src8 [4];
    logic [DW-1:0] dst8 [64];
    logic          fill_en;
    logic [DW-1:0] fill_val;

    // Synchronous-read BRAM models (source and destination maps).
    always @(posedge clk) begin
        bus.rd_data <= src_mem[bus.rd_addr[1:0]];
        if (fill_en) begin
            for (int i = 0; i < RR; i++) dst_mem[i] <= fill_val;
        end else if (bus.wr_en) begin
            dst_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always @(posedge clk) begin
        bus8.rd_data <= src8[bus8.rd_addr[1:0]];
        if (bus8.wr_en) dst8[bus8.wr_addr] <= bus8.wr_data;
    end

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, rel = 0, s8 = 0, max_rd = 0;
    int m_t = -1;
    logic chk_en = 1'b0, trace_on = 1'b0;
    int trace_q[$];
    int trace_cyc[$];
    int lit_dst[16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
    int lit_wa[16]  = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // k-th write of a pass: window k/KK in raster order, kc fastest inside the window.
    function automatic int exp_waddr(input int k);
        int w, j;
        w = k / KK;
        j = k % KK;
        return ((w / P) * K + j / K) * R + (w % P) * K + j % K;
    endfunction

    function automatic int exp_raddr(input int t);
        if (t == 1) return 0;
        if (t == 2) return (NS > 1) ? 1 : 0;
        if (t >= 3 && t < DONE_T) return ((t - 3) / KK + 1 < NS) ? (t - 3) / KK + 1 : NS - 1;
        return 0;
    endfunction

    function automatic int in_write();
        return (rst == 1'b0 && m_t >= 3 && m_t < DONE_T) ? 1 : 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_t is cycles since the accepted start (-1 = idle).
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < RR; i++) exp_dst[i] <= fill_val;
        end else if (in_write() == 1) begin
            exp_dst[exp_waddr(m_t - 3)] <= src_mem[(m_t - 3) / KK];
        end
        if (rst) m_t <= -1;
        else if (m_t < 0) m_t <= bus.start ? 1 : -1;
        else if (m_t == DONE_T) m_t <= -1;
        else m_t <= m_t + 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), (!rst && m_t >= 1 && m_t < DONE_T) ? 1 : 0);
            check("done", 32'(bus.done), (!rst && m_t == DONE_T) ? 1 : 0);
            check("wr_en", 32'(bus.wr_en), in_write());
            check("wr_addr", 32'(bus.wr_addr), (in_write() == 1) ? exp_waddr(m_t - 3) : 0);
            check("wr_data", 32'(bus.wr_data), (in_write() == 1) ? 32'(src_mem[(m_t - 3) / KK]) : 0);
            check("rd_addr", 32'(bus.rd_addr), rst ? 0 : exp_raddr(m_t));
        end
    end

    always @(negedge clk) begin
        if (trace_on) begin
            if (bus.wr_en) begin
                trace_q.push_back(int'(bus.wr_addr));
                trace_cyc.push_back(cyc - start_cyc);
            end
            if (int'(bus.rd_addr) > max_rd) max_rd <= int'(bus.rd_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int r);
        r = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                r = cyc - start_cyc;
                break;
            end
        end
    endtask

    task automatic compare_map(input string name);
        for (int i = 0; i < RR; i++) check(name, 32'(dst_mem[i]), 32'(exp_dst[i]));
    endtask

    task automatic randomize_src();
        for (int i = 0; i < NS; i++) src_mem[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; rst8 = 1'b1;
        bus.start = 1'b0; bus8.start = 1'b0;
        fill_en = 1'b1; fill_val = 8'd0;
        src_mem = '{8'd10, 8'd20, 8'd30, 8'd40};
        src8 = '{8'hFF, 8'h00, 8'h7F, 8'h80};
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0; fill_en = 1'b0;
        tick();

        // Literal pass with {10,20,30,40}.
        trace_on = 1'b1;
        bus.start = 1'b1; start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        wait_done(100, rel);
        check("done_cycle", rel, 19);
        tick();
        trace_on = 1'b0;
        check("write_count", trace_q.size(), 16);
        check("max_rd_addr", max_rd, 3);
        for (int i = 0; i < 16 && i < trace_q.size(); i++) begin
            check("wr_addr_trace", trace_q[i], lit_wa[i]);
            check("wr_cycle", trace_cyc[i], 3 + i);
        end
        for (int i = 0; i < RR; i++) begin
            check("dst_literal", 32'(dst_mem[i]), lit_dst[i]);
            check("model_literal", 32'(exp_dst[i]), lit_dst[i]);
        end

        // start held high: back-to-back passes, period 20 cycles.
        randomize_src();
        bus.start = 1'b1; start_cyc = cyc;
        for (int p = 0; p < 3; p++) begin
            wait_done(100, rel);
            check("b2b_done_cycle", rel, 19 + 20 * p);
        end
        bus.start = 1'b0;
        tick();
        tick();
        compare_map("b2b_map");

        // Reset at cycle 8 of a pass leaves the untouched words alone.
        fill_en = 1'b1; fill_val = 8'hEE;
        tick();
        fill_en = 1'b0;
        randomize_src();
        bus.start = 1'b1; start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        compare_map("rst_partial_map");
        check("rst_written_2", 32'(dst_mem[2]), 32'(src_mem[1]));
        check("rst_kept_3", 32'(dst_mem[3]), 32'hEE);
        check("rst_kept_15", 32'(dst_mem[15]), 32'hEE);
        bus.start = 1'b1; start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        wait_done(100, rel);
        check("post_rst_done_cycle", rel, 19);
        tick();
        compare_map("post_rst_map");
        check("post_rst_15", 32'(dst_mem[15]), 32'(src_mem[3]));

        // Random start/reset traffic.
        for (int b = 0; b < 6; b++) begin
            rst = 1'b1;
            randomize_src();
            tick();
            rst = 1'b0;
            for (int c = 0; c < 120; c++) begin
                bus.start = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 79) == 0);
                tick();
            end
            rst = 1'b0; bus.start = 1'b0;
            repeat (25) tick();
            compare_map("random_map");
        end

        // 8x8 map, 4x4 kernel.
        rst8 = 1'b0;
        tick();
        bus8.start = 1'b1; s8 = cyc;
        tick();
        bus8.start = 1'b0;
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) begin
                rel = cyc - s8;
                break;
            end
        end
        check("done_cycle_8x8", rel, 67);
        tick();
        for (int r = 0; r < R8; r++) begin
            for (int c = 0; c < R8; c++) begin
                check("quadrant", 32'(dst8[r * R8 + c]), 32'(src8[(r / K8) * 2 + c / K8]));
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
